// File: rtl/score_bin_to_bcd.sv
// -----------------------------------------------------------------------------
// score_bin_to_bcd
//
// Sequential binary-to-BCD converter feeding the 7-segment display controller.
// Performs one double-dabble step per clock. Inputs above MAX_VALUE are
// clamped to MAX_VALUE and flagged. While a conversion runs, one extra request
// can wait in a pending slot, and a newer request replaces the waiting one.
// The display word is a held register that updates only when a conversion
// completes.
//
// Handshake: score_valid is a single-cycle request and is always accepted.
// In IDLE it starts a conversion. During CONVERT it fills the pending slot.
// On the completion edge it starts the next conversion directly, and the
// newest request wins over the pending slot. There is no back-pressure.
// busy is high while a conversion is in flight. done pulses for one cycle
// when bcd_score and overflow update.
//
// Ports:
//   clk          system clock
//   rst          asynchronous, active-high reset
//   score_in     binary score, sampled when score_valid=1
//   score_valid  single-cycle conversion request
//   bcd_score    last completed result, digit 0 in [3:0]
//   busy         conversion in progress
//   done         one-cycle pulse when bcd_score updates
//   overflow     last completed conversion was clamped
// -----------------------------------------------------------------------------
module score_bin_to_bcd #(
   parameter int BIN_W     = 17,
   parameter int DIGITS    = 5,
   parameter int MAX_VALUE = 99999
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [BIN_W-1:0]      score_in,
   input  logic                  score_valid,
   output logic [4*DIGITS-1:0]   bcd_score,
   output logic                  busy,
   output logic                  done,
   output logic                  overflow
);

   localparam int                 BCD_W   = 4 * DIGITS;
   localparam int                 CNT_W   = $clog2(BIN_W);
   localparam logic [BIN_W-1:0]   MAX_BIN = BIN_W'(MAX_VALUE);
   localparam logic [CNT_W-1:0]   LAST    = CNT_W'(BIN_W - 1);

   typedef enum logic {IDLE, CONVERT} state_t;

   state_t               state, state_n;
   logic [BIN_W-1:0]     bin_sr;
   logic [BCD_W-1:0]     scratch;
   logic [CNT_W-1:0]     cnt;
   logic                 ovf;
   logic                 pend_valid;
   logic [BIN_W-1:0]     pend_val;
   logic                 pend_ovf;

   // Clamped view of the incoming request.
   logic                 in_ovf;
   logic [BIN_W-1:0]     in_val;

   // One double-dabble step.
   logic [BCD_W-1:0]       dab;
   logic [BCD_W+BIN_W-1:0] shifted;

   // Controls from the next-state logic.
   logic                 load;
   logic [BIN_W-1:0]     load_val;
   logic                 load_ovf;
   logic                 finish;
   logic                 pend_set;
   logic                 pend_clr;

   assign in_ovf = (score_in > MAX_BIN);
   assign in_val = in_ovf ? MAX_BIN : score_in;
   assign busy   = (state == CONVERT);

   always_comb begin
      dab = scratch;
      for (int i = 0; i < DIGITS; i++) begin
         if (scratch[4*i +: 4] >= 4'd5) begin
            dab[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
         end
      end
      shifted = {dab, bin_sr} << 1;
   end

   // Next state and datapath controls.
   always_comb begin
      state_n  = state;
      load     = 1'b0;
      load_val = in_val;
      load_ovf = in_ovf;
      finish   = 1'b0;
      pend_set = 1'b0;
      pend_clr = 1'b0;
      case (state)
         IDLE: begin
            if (score_valid) begin
               load    = 1'b1;
               state_n = CONVERT;
            end
         end
         CONVERT: begin
            if (cnt == LAST) begin
               finish   = 1'b1;
               pend_clr = 1'b1;
               if (score_valid) begin
                  load = 1'b1;
               end else if (pend_valid) begin
                  load     = 1'b1;
                  load_val = pend_val;
                  load_ovf = pend_ovf;
               end else begin
                  state_n = IDLE;
               end
            end else if (score_valid) begin
               pend_set = 1'b1;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_n;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bin_sr     <= '0;
         scratch    <= '0;
         cnt        <= '0;
         ovf        <= 1'b0;
         pend_valid <= 1'b0;
         pend_val   <= '0;
         pend_ovf   <= 1'b0;
         bcd_score  <= '0;
         overflow   <= 1'b0;
         done       <= 1'b0;
      end else begin
         done <= finish;
         // The final step's shifted scratch is the result. ovf still holds
         // the flag of the conversion that is finishing here.
         if (finish) begin
            bcd_score <= shifted[BCD_W+BIN_W-1:BIN_W];
            overflow  <= ovf;
         end
         if (load) begin
            bin_sr  <= load_val;
            scratch <= '0;
            cnt     <= '0;
            ovf     <= load_ovf;
         end else if (state == CONVERT) begin
            bin_sr  <= shifted[BIN_W-1:0];
            scratch <= shifted[BCD_W+BIN_W-1:BIN_W];
            cnt     <= cnt + 1'b1;
         end
         if (pend_clr) begin
            pend_valid <= 1'b0;
         end else if (pend_set) begin
            pend_valid <= 1'b1;
            pend_val   <= in_val;
            pend_ovf   <= in_ovf;
         end
      end
   end

endmodule

// File: tb/tb_score_bin_to_bcd.sv
// -----------------------------------------------------------------------------
// tb_score_bin_to_bcd
//
// Directed bench for score_bin_to_bcd. Each request whose result should reach
// the display is pushed as {overflow, bcd} to exp_q when it is driven. The
// monitor pops and compares an entry on every done pulse. Requests that are
// expected to be overwritten or dropped are never pushed.
// -----------------------------------------------------------------------------
module tb_score_bin_to_bcd;

   localparam int BIN_W  = 17;
   localparam int DIGITS = 5;
   localparam int BCD_W  = 4 * DIGITS;

   logic               clk;
   logic               rst;
   logic [BIN_W-1:0]   score_in;
   logic               score_valid;
   logic [BCD_W-1:0]   bcd_score;
   logic               busy;
   logic               done;
   logic               overflow;

   int errors = 0;
   int checks = 0;
   logic [BCD_W:0] exp_q[$];

   score_bin_to_bcd dut (
      .clk         (clk),
      .rst         (rst),
      .score_in    (score_in),
      .score_valid (score_valid),
      .bcd_score   (bcd_score),
      .busy        (busy),
      .done        (done),
      .overflow    (overflow)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: clamp the value, then extract decimal digits.
   function automatic logic [BCD_W:0] model(input int v);
      logic [BCD_W:0] r;
      int c;
      r = '0;
      c = (v > 99999) ? 99999 : v;
      r[BCD_W] = (v > 99999);
      for (int i = 0; i < DIGITS; i++) begin
         r[4*i +: 4] = 4'(c % 10);
         c = c / 10;
      end
      return r;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Driver: call at a negedge. The request is sampled on the next posedge,
   // and the task returns on the following negedge.
   task automatic pulse(input int v);
      score_in    = BIN_W'(v);
      score_valid = 1'b1;
      @(negedge clk);
      score_valid = 1'b0;
   endtask

   // Wait for done. Check that busy stays high while waiting, then check the
   // latency in cycles and the busy value in the done cycle.
   task automatic wait_done(input string tag, input int exp_lat, input logic exp_busy);
      int n;
      n = 0;
      check({tag, "_busy_start"}, 32'(busy), 32'd1);
      while (n < 100) begin
         @(negedge clk);
         n++;
         if (done === 1'b1) break;
         if (busy !== 1'b1) check({tag, "_busy_mid"}, 32'(busy), 32'd1);
      end
      check({tag, "_latency"}, 32'(n), 32'(exp_lat));
      check({tag, "_busy_at_done"}, 32'(busy), 32'(exp_busy));
   endtask

   // scoreboard monitor
   always @(negedge clk) begin
      if (rst === 1'b0 && done === 1'b1) begin
         if (exp_q.size() == 0) begin
            check("unexpected_done", 32'(done), 32'd0);
         end else begin
            check("done_result", 32'({overflow, bcd_score}), 32'(exp_q.pop_front()));
         end
      end
   end

   initial begin
      int seen_done;
      rst         = 1'b1;
      score_in    = '0;
      score_valid = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_bcd", 32'(bcd_score), 32'd0);
      check("reset_busy", 32'(busy), 32'd0);
      check("reset_done", 32'(done), 32'd0);
      check("reset_ovf", 32'(overflow), 32'd0);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      check("idle_busy", 32'(busy), 32'd0);

      // Single conversions, including the clamp boundary.
      exp_q.push_back(model(0));      pulse(0);      wait_done("zero", 17, 1'b0);
      exp_q.push_back(model(2048));   pulse(2048);   wait_done("v2048", 17, 1'b0);
      @(negedge clk);
      exp_q.push_back(model(65536));  pulse(65536);  wait_done("v65536", 17, 1'b0);
      exp_q.push_back(model(99999));  pulse(99999);  wait_done("v99999", 17, 1'b0);
      exp_q.push_back(model(131071)); pulse(131071); wait_done("v131071", 17, 1'b0);
      repeat (3) @(negedge clk);
      check("held_ovf", 32'(overflow), 32'd1);
      check("held_bcd", 32'(bcd_score), 32'h99999);
      exp_q.push_back(model(5));      pulse(5);      wait_done("v5", 17, 1'b0);
      check("ovf_cleared", 32'(overflow), 32'd0);

      // Pending slot: 200 is overwritten by 300.
      repeat (2) @(negedge clk);
      exp_q.push_back(model(100));
      pulse(100);
      repeat (4) @(negedge clk);
      pulse(200);
      repeat (3) @(negedge clk);
      exp_q.push_back(model(300));
      pulse(300);
      wait_done("pend_first", 8, 1'b1);
      wait_done("pend_second", 17, 1'b0);

      // A request on the completion edge beats the pending value 1.
      repeat (2) @(negedge clk);
      exp_q.push_back(model(12345));
      pulse(12345);
      repeat (2) @(negedge clk);
      pulse(1);
      repeat (13) @(negedge clk);
      exp_q.push_back(model(777));
      pulse(777);
      check("edge_done", 32'(done), 32'd1);
      check("edge_busy", 32'(busy), 32'd1);
      wait_done("v777", 17, 1'b0);

      // Reset in the middle of a conversion aborts it.
      repeat (2) @(negedge clk);
      pulse(4096);
      repeat (7) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("abort_bcd", 32'(bcd_score), 32'd0);
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_done", 32'(done), 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      seen_done = 0;
      repeat (25) begin
         @(negedge clk);
         if (done === 1'b1) seen_done++;
      end
      check("abort_no_done", 32'(seen_done), 32'd0);
      check("abort_idle", 32'(busy), 32'd0);
      exp_q.push_back(model(4096));
      pulse(4096);
      wait_done("v4096", 17, 1'b0);

      repeat (3) @(negedge clk);
      check("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
